mem_stage: RTL and testbench

- MEM pipeline stage, directly downstream of the execute stage's EX/MEM register.
- Consumes ALU result (address or data), store data, destination register, MemToReg/RegWrite/MemRead/MemWrite and trunk_mode.
- Contains the word-organised data RAM with byte/half/word access, load extension and the MEM/WB pipeline register.
- Drives write-back and the forwarding value returned to the execute stage's memory_mem_wb input.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/data_ram_be.sv | 35 +++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-width codes and lane helpers.
package mem_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;

  localparam logic [2:0] TM_WORD   = 3'b000;
  localparam logic [2:0] TM_HALF_U = 3'b001;
  localparam logic [2:0] TM_HALF_S = 3'b010;
  localparam logic [2:0] TM_BYTE_U = 3'b011;
  localparam logic [2:0] TM_BYTE_S = 3'b100;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } acc_size_e;

  function automatic acc_size_e decode_size(input logic [2:0] tm);
    case (tm)
      TM_HALF_U, TM_HALF_S: return SZ_HALF;
      TM_BYTE_U, TM_BYTE_S: return SZ_BYTE;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Selects the addressed lane of a little-endian word and zero/sign extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  tm,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (tm)
      TM_HALF_U: r = {16'h0000, h};
      TM_HALF_S: r = {{16{h[15]}}, h};
      TM_BYTE_U: r = {24'h000000, b};
      TM_BYTE_S: r = {{24{b[7]}}, b};
      default:   r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_ram_be.sv
// Word-organised RAM with per-byte write enables, read-first synchronous read
// and an independent asynchronous debug read port.
module data_ram_be
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [31:0]       dbg_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Contents start at zero and are deliberately untouched by reset.
  logic [31:0] mem_q [DEPTH] = '{default: '0};
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[addr_i];
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data RAM access with byte/half/word lanes, load
// extension, misalignment detection and the MEM/WB register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        reg_dest_in,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [2:0]        trunk_mode_in,
  output logic [31:0]       read_data_out,
  output logic [31:0]       alu_result_out,
  output logic [4:0]        reg_dest_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic [31:0]       wb_value_out,
  output logic              misaligned_flag,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [31:0]       debug_data
);

  logic [1:0]        off;
  logic [ADDR_W-1:0] word_idx;
  acc_size_e         size;
  logic              misaligned;
  logic [3:0]        be;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0] alu_q;
  logic [4:0]  rd_q;
  logic        m2r_q;
  logic        rw_q,      rw_d;
  logic        load_ok_q, load_ok_d;
  logic [2:0]  tm_q;
  logic [1:0]  off_q;
  logic        flag_q,    flag_d;

  assign off      = alu_result_in[1:0];
  assign word_idx = alu_result_in[ADDR_W+1:2];
  assign size     = decode_size(trunk_mode_in);

  always_comb begin
    misaligned = 1'b0;
    be         = 4'hF;
    ram_wdata  = store_data_in;
    case (size)
      SZ_HALF: begin
        misaligned = off[0];
        be         = off[1] ? 4'hC : 4'h3;
        ram_wdata  = {2{store_data_in[15:0]}};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        ram_wdata = {4{store_data_in[7:0]}};
      end
      default: misaligned = (off != 2'b00);
    endcase
    misaligned = misaligned & (MemRead_in | MemWrite_in);
    ram_we     = (MemWrite_in && !misaligned && !reset) ? be : '0;
    rw_d       = RegWrite_in & ~(MemRead_in & misaligned);
    load_ok_d  = MemRead_in & ~misaligned;
    flag_d     = flag_q | misaligned;
  end

  data_ram_be #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i      (clock),
    .addr_i     (word_idx),
    .we_i       (ram_we),
    .wdata_i    (ram_wdata),
    .rdata_o    (ram_rdata),
    .dbg_addr_i (debug_addr),
    .dbg_data_o (debug_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_q     <= '0;
      rd_q      <= '0;
      m2r_q     <= 1'b0;
      rw_q      <= 1'b0;
      load_ok_q <= 1'b0;
      tm_q      <= '0;
      off_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      alu_q     <= alu_result_in;
      rd_q      <= reg_dest_in;
      m2r_q     <= MemToReg_in;
      rw_q      <= rw_d;
      load_ok_q <= load_ok_d;
      tm_q      <= trunk_mode_in;
      off_q     <= off;
      flag_q    <= flag_d;
    end
  end

  // RAM word is already registered; lane select/extension is applied on its
  // output using the captured mode and offset, giving the same 1-cycle latency.
  assign read_data_out   = load_ok_q ? load_extend(ram_rdata, tm_q, off_q) : '0;
  assign alu_result_out  = alu_q;
  assign reg_dest_out    = rd_q;
  assign MemToReg_out    = m2r_q;
  assign RegWrite_out    = rw_q;
  assign wb_value_out    = m2r_q ? read_data_out : alu_q;
  assign misaligned_flag = flag_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_mem_stage;

  logic        clock;
  logic        reset;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  reg_dest_in;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [2:0]  trunk_mode_in;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  reg_dest_out;
  logic        MemToReg_out;
  logic        RegWrite_out;
  logic [31:0] wb_value_out;
  logic        misaligned_flag;
  logic [7:0]  debug_addr;
  logic [31:0] debug_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model: byte-addressed memory and expected registered outputs
  logic [7:0]  m_bytes [1024];
  logic        m_flag;
  logic [31:0] e_read, e_alu, e_wb;
  logic [4:0]  e_rd;
  logic        e_m2r, e_rw;

  mem_stage #(.ADDR_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .reg_dest_in     (reg_dest_in),
    .MemToReg_in     (MemToReg_in),
    .RegWrite_in     (RegWrite_in),
    .MemRead_in      (MemRead_in),
    .MemWrite_in     (MemWrite_in),
    .trunk_mode_in   (trunk_mode_in),
    .read_data_out   (read_data_out),
    .alu_result_out  (alu_result_out),
    .reg_dest_out    (reg_dest_out),
    .MemToReg_out    (MemToReg_out),
    .RegWrite_out    (RegWrite_out),
    .wb_value_out    (wb_value_out),
    .misaligned_flag (misaligned_flag),
    .debug_addr      (debug_addr),
    .debug_data      (debug_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_word(input int unsigned widx);
    int unsigned b;
    b = (widx % 256) * 4;
    return {m_bytes[b+3], m_bytes[b+2], m_bytes[b+1], m_bytes[b]};
  endfunction

  // Drive one instruction, predict the post-edge outputs, then advance one clock.
  task automatic cycle(input logic rst, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic m2r, input logic rw,
                       input logic mr, input logic mw, input logic [2:0] tm);
    int unsigned sz, off, base;
    logic        mis, sgn;
    longint      v;
    reset = rst; alu_result_in = alu; store_data_in = sd; reg_dest_in = rd;
    MemToReg_in = m2r; RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw;
    trunk_mode_in = tm;
    if (rst) begin
      e_read = 0; e_alu = 0; e_rd = 0; e_m2r = 0; e_rw = 0; m_flag = 0;
    end else begin
      sz   = (tm == 3'd1 || tm == 3'd2) ? 2 : (tm == 3'd3 || tm == 3'd4) ? 1 : 4;
      sgn  = (tm == 3'd2 || tm == 3'd4);
      off  = alu % 4;
      base = ((alu / 4) % 256) * 4;
      mis  = (mr || mw) && (off % sz != 0);
      if (mr && !mis) begin
        v = 0;
        for (int i = sz - 1; i >= 0; i--) v = v * 256 + m_bytes[base + off + i];
        if (sgn && v >= (64'sd1 << (8*sz - 1))) v = v - (64'sd1 << (8*sz));
        e_read = 32'(v);
      end else begin
        e_read = 0;
      end
      e_alu = alu; e_rd = rd; e_m2r = m2r;
      e_rw  = rw && !(mr && mis);
      if (mis) m_flag = 1;
      if (mw && !mis)
        for (int i = 0; i < sz; i++) m_bytes[base + off + i] = 8'(sd >> (8*i));
    end
    e_wb = e_m2r ? e_read : e_alu;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 32'h10, 32'h1111_1111, 5'd3, 1, 1, 0, 1, 3'd0);
    cycle(1, 32'h10, 32'h1111_1111, 5'd3, 1, 1, 0, 1, 3'd0);
    n_checks++;
    if ({read_data_out, alu_result_out, reg_dest_out, MemToReg_out, RegWrite_out,
         wb_value_out, misaligned_flag} !== '0)
      $display("FAIL reset_outputs: got rd=%h alu=%h dst=%h m2r=%b rw=%b wb=%h flag=%b required all 0",
               read_data_out, alu_result_out, reg_dest_out, MemToReg_out, RegWrite_out,
               wb_value_out, misaligned_flag);
    else n_pass++;
    debug_addr = 8'd4; #1;
    n_checks++;
    if (debug_data !== 32'h0) $display("FAIL reset_store_suppressed: got %h required %h", debug_data, 32'h0);
    else n_pass++;
    cycle(0, 32'h10, 32'h0, 5'd1, 1, 1, 1, 0, 3'd0);
    n_checks++;
    if (read_data_out !== 32'h0) $display("FAIL reset_lw: got %h required %h", read_data_out, 32'h0);
    else n_pass++;
  endtask

  task automatic test_store_load();
    cycle(0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 1, 3'd0);
    cycle(0, 32'h10, 32'h0, 5'd7, 1, 1, 1, 0, 3'd0);
    n_checks++;
    if (read_data_out !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h required %h", read_data_out, 32'hDEAD_BEEF);
    else n_pass++;
    n_checks++;
    if (wb_value_out !== 32'hDEAD_BEEF) $display("FAIL wb_mem: got %h required %h", wb_value_out, 32'hDEAD_BEEF);
    else n_pass++;
    n_checks++;
    if (RegWrite_out !== 1'b1 || reg_dest_out !== 5'd7)
      $display("FAIL lw_ctrl: got rw=%b dst=%0d required rw=1 dst=7", RegWrite_out, reg_dest_out);
    else n_pass++;
    cycle(0, 32'h10, 32'h0, 5'd7, 0, 1, 1, 0, 3'd0);
    n_checks++;
    if (wb_value_out !== 32'h10) $display("FAIL wb_alu: got %h required %h", wb_value_out, 32'h10);
    else n_pass++;
  endtask

  task automatic test_lane_loads();
    logic [2:0]  tms  [4] = '{3'd4, 3'd3, 3'd2, 3'd1};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i < 4; i++) begin
      cycle(0, adrs[i], 32'h0, 5'd2, 1, 1, 1, 0, tms[i]);
      n_checks++;
      if (read_data_out !== exps[i])
        $display("FAIL lane_load_tm%0d: got %h required %h", tms[i], read_data_out, exps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_partial_stores();
    debug_addr = 8'd4;
    cycle(0, 32'h11, 32'h1234_5655, 5'd0, 0, 0, 0, 1, 3'd3);
    n_checks++;
    if (debug_data !== 32'hDEAD_55EF) $display("FAIL sb_lane: got %h required %h", debug_data, 32'hDEAD_55EF);
    else n_pass++;
    cycle(0, 32'h12, 32'h0000_CAFE, 5'd0, 0, 0, 0, 1, 3'd1);
    n_checks++;
    if (debug_data !== 32'hCAFE_55EF) $display("FAIL sh_lane: got %h required %h", debug_data, 32'hCAFE_55EF);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    debug_addr = 8'd4;
    cycle(0, 32'h12, 32'h0, 5'd9, 0, 1, 1, 0, 3'd0);
    n_checks++;
    if (read_data_out !== 32'h0 || RegWrite_out !== 1'b0 || misaligned_flag !== 1'b1)
      $display("FAIL misaligned_lw: got rd=%h rw=%b flag=%b required rd=0 rw=0 flag=1",
               read_data_out, RegWrite_out, misaligned_flag);
    else n_pass++;
    cycle(0, 32'h40, 32'h0, 5'd9, 0, 1, 0, 0, 3'd0);
    n_checks++;
    if (misaligned_flag !== 1'b1) $display("FAIL flag_sticky: got %b required 1", misaligned_flag);
    else n_pass++;
    cycle(0, 32'h11, 32'h0000_9999, 5'd0, 0, 0, 0, 1, 3'd1);
    n_checks++;
    if (debug_data !== 32'hCAFE_55EF) $display("FAIL misaligned_sh: got %h required %h", debug_data, 32'hCAFE_55EF);
    else n_pass++;
    cycle(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 3'd0);
    n_checks++;
    if (misaligned_flag !== 1'b0) $display("FAIL flag_reset: got %b required 0", misaligned_flag);
    else n_pass++;
  endtask

  task automatic test_read_write_same();
    cycle(0, 32'h20, 32'h0102_0304, 5'd0, 0, 0, 0, 1, 3'd0);
    cycle(0, 32'h20, 32'hA5A5_A5A5, 5'd4, 1, 1, 1, 1, 3'd0);
    n_checks++;
    if (read_data_out !== 32'h0102_0304) $display("FAIL read_first: got %h required %h", read_data_out, 32'h0102_0304);
    else n_pass++;
    cycle(0, 32'h20, 32'h0, 5'd4, 1, 1, 1, 0, 3'd0);
    n_checks++;
    if (read_data_out !== 32'hA5A5_A5A5) $display("FAIL after_rw: got %h required %h", read_data_out, 32'hA5A5_A5A5);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] alu;
    for (int n = 0; n < 400; n++) begin
      alu = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      cycle($urandom_range(0, 39) == 0, alu, $urandom, 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
      n_checks++;
      if (read_data_out !== e_read || alu_result_out !== e_alu || reg_dest_out !== e_rd ||
          MemToReg_out !== e_m2r || RegWrite_out !== e_rw || wb_value_out !== e_wb ||
          misaligned_flag !== m_flag)
        $display("FAIL random_%0d: got rd=%h alu=%h dst=%h m2r=%b rw=%b wb=%h flag=%b required rd=%h alu=%h dst=%h m2r=%b rw=%b wb=%h flag=%b",
                 n, read_data_out, alu_result_out, reg_dest_out, MemToReg_out, RegWrite_out,
                 wb_value_out, misaligned_flag, e_read, e_alu, e_rd, e_m2r, e_rw, e_wb, m_flag);
      else n_pass++;
      debug_addr = 8'($urandom_range(0, 15)); #1;
      n_checks++;
      if (debug_data !== model_word(debug_addr))
        $display("FAIL random_debug_%0d: got %h required %h", n, debug_data, model_word(debug_addr));
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_bytes[i] = 8'h00;
    m_flag = 0;
    reset = 1; alu_result_in = 0; store_data_in = 0; reg_dest_in = 0;
    MemToReg_in = 0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0;
    trunk_mode_in = 0; debug_addr = 0;
    #1;
    test_reset();
    test_store_load();
    test_lane_loads();
    test_partial_stores();
    test_misaligned();
    test_read_write_same();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
